// File: rtl/canny_accel_hls_deadlock_report_unit_pkg.sv
// Shared types and constants for the canny_accel deadlock report collector.
// Holds the FSM state encoding and the width helper used to size indices and counters.
package canny_accel_hls_deadlock_report_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONFIRM = 3'd1,
        ST_ORIGIN  = 3'd2,
        ST_TRACE   = 3'd3,
        ST_REPORT  = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam int TRACE_TIMEOUT_DEF = 64;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A single-process design still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/canny_accel_hls_deadlock_prio_enc.sv
// Lowest-index priority encoder over the per-process detect bits.
// Purely combinational, zero latency; no handshake.
module canny_accel_hls_deadlock_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         vld_o
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        vld_o = |vec_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

endmodule

// File: rtl/canny_accel_hls_deadlock_report_unit.sv
// Confirms a deadlock, launches a token from one elected origin and latches the loop it traces.
// origin_vec fires the cycle after the CONFIRM_CYCLES-th sampling edge; the report holds until report_ack.
module canny_accel_hls_deadlock_report_unit
    import canny_accel_hls_deadlock_report_unit_pkg::*;
#(
    parameter int PROC_NUM       = 4,
    parameter int CONFIRM_CYCLES = 2,
    parameter int TRACE_TIMEOUT  = TRACE_TIMEOUT_DEF,
    localparam int IDX_W         = idx_width(PROC_NUM)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] token_seen_vec,
    input  logic                report_ack,
    output logic                dl_detect_bcast,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                token_clear,
    output logic                dl_global,
    output logic                report_valid,
    output logic [IDX_W-1:0]    origin_idx,
    output logic [PROC_NUM-1:0] loop_vec,
    output logic                trace_timeout
);

    localparam int CNT_W  = clog2(CONFIRM_CYCLES) + 1;
    localparam int TCNT_W = clog2(TRACE_TIMEOUT) + 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    origin_idx_q, origin_idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [PROC_NUM-1:0] loop_vec_q, loop_vec_d;
    logic                timeout_q, timeout_d;
    logic                global_q, global_d;
    logic                valid_q, valid_d;
    logic                bcast_q, bcast_d;

    logic [IDX_W-1:0]    enc_idx;
    logic                enc_vld;
    logic [PROC_NUM-1:0] origin_oh;
    logic                token_back;

    canny_accel_hls_deadlock_prio_enc #(
        .N (PROC_NUM),
        .W (IDX_W)
    ) u_prio_enc (
        .vec_i (dl_detect_vec),
        .idx_o (enc_idx),
        .vld_o (enc_vld)
    );

    assign origin_oh  = PROC_NUM'(1) << origin_idx_q;
    // Combinational so the clear lands in the very cycle the token reaches the origin.
    assign token_back = (state_q == ST_TRACE) && token_seen_vec[origin_idx_q];

    always_comb begin
        state_d      = state_q;
        origin_idx_d = origin_idx_q;
        cnt_d        = cnt_q;
        tcnt_d       = tcnt_q;
        loop_vec_d   = loop_vec_q;
        timeout_d    = timeout_q;
        global_d     = global_q;
        valid_d      = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_vld) begin
                    origin_idx_d = enc_idx;
                    cnt_d        = CNT_W'(1);
                    state_d      = (CONFIRM_CYCLES == 1) ? ST_ORIGIN : ST_CONFIRM;
                end
            end
            ST_CONFIRM: begin
                if (dl_detect_vec[origin_idx_q]) begin
                    if (cnt_q + CNT_W'(1) == CNT_W'(CONFIRM_CYCLES)) begin
                        state_d = ST_ORIGIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ORIGIN: begin
                loop_vec_d = origin_oh;
                tcnt_d     = '0;
                state_d    = ST_TRACE;
            end
            ST_TRACE: begin
                loop_vec_d = loop_vec_q | token_seen_vec;
                tcnt_d     = tcnt_q + TCNT_W'(1);
                // A return wins over a simultaneous timeout.
                if (token_back || (tcnt_q == TCNT_W'(TRACE_TIMEOUT - 1))) begin
                    timeout_d = !token_back;
                    valid_d   = 1'b1;
                    global_d  = 1'b1;
                    state_d   = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (report_ack) begin
                    valid_d = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (dl_detect_vec == '0) begin
                    global_d   = 1'b0;
                    timeout_d  = 1'b0;
                    loop_vec_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        bcast_d = (state_d == ST_ORIGIN) || (state_d == ST_TRACE) ||
                  (state_d == ST_REPORT) || (state_d == ST_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            origin_idx_q <= '0;
            cnt_q        <= '0;
            tcnt_q       <= '0;
            loop_vec_q   <= '0;
            timeout_q    <= 1'b0;
            global_q     <= 1'b0;
            valid_q      <= 1'b0;
            bcast_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            origin_idx_q <= origin_idx_d;
            cnt_q        <= cnt_d;
            tcnt_q       <= tcnt_d;
            loop_vec_q   <= loop_vec_d;
            timeout_q    <= timeout_d;
            global_q     <= global_d;
            valid_q      <= valid_d;
            bcast_q      <= bcast_d;
        end
    end

    assign dl_detect_bcast = bcast_q;
    assign origin_vec      = (state_q == ST_ORIGIN) ? origin_oh : '0;
    assign token_clear     = token_back;
    assign dl_global       = global_q;
    assign report_valid    = valid_q;
    assign origin_idx      = origin_idx_q;
    assign loop_vec        = loop_vec_q;
    assign trace_timeout   = timeout_q;

endmodule

// File: tb/tb_canny_accel_hls_deadlock_report_unit.sv
// Directed bench for the deadlock report collector (4 processes, confirm 2, trace timeout 8).
module tb_canny_accel_hls_deadlock_report_unit;

    logic       clock;
    logic       reset;
    logic [3:0] dl_detect_vec;
    logic [3:0] token_seen_vec;
    logic       report_ack;
    logic       dl_detect_bcast;
    logic [3:0] origin_vec;
    logic       token_clear;
    logic       dl_global;
    logic       report_valid;
    logic [1:0] origin_idx;
    logic [3:0] loop_vec;
    logic       trace_timeout;

    int n_checks;
    int n_fail;

    canny_accel_hls_deadlock_report_unit #(
        .PROC_NUM       (4),
        .CONFIRM_CYCLES (2),
        .TRACE_TIMEOUT  (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .dl_detect_vec   (dl_detect_vec),
        .token_seen_vec  (token_seen_vec),
        .report_ack      (report_ack),
        .dl_detect_bcast (dl_detect_bcast),
        .origin_vec      (origin_vec),
        .token_clear     (token_clear),
        .dl_global       (dl_global),
        .report_valid    (report_valid),
        .origin_idx      (origin_idx),
        .loop_vec        (loop_vec),
        .trace_timeout   (trace_timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs are then changed 2 units later, outputs checked at 3.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_bcast"},   32'(dl_detect_bcast), 32'h0);
        check_eq({tag, "_origin"},  32'(origin_vec),      32'h0);
        check_eq({tag, "_tclr"},    32'(token_clear),     32'h0);
        check_eq({tag, "_global"},  32'(dl_global),       32'h0);
        check_eq({tag, "_valid"},   32'(report_valid),    32'h0);
        check_eq({tag, "_oidx"},    32'(origin_idx),      32'h0);
        check_eq({tag, "_loop"},    32'(loop_vec),        32'h0);
        check_eq({tag, "_timeout"}, 32'(trace_timeout),   32'h0);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        dl_detect_vec  = 4'b0;
        token_seen_vec = 4'b0;
        report_ack     = 1'b0;
        #3;
        check_all_zero("rst");
        step();
        step();
        reset = 1'b0;
        #1;

        // Confirm and elect: lowest set bit of 0110 is process 1.
        dl_detect_vec = 4'b0110;
        step();
        #1;
        check_eq("conf1_origin", 32'(origin_vec), 32'h0);
        check_eq("conf1_oidx",   32'(origin_idx), 32'h1);
        check_eq("conf1_bcast",  32'(dl_detect_bcast), 32'h0);
        step();
        token_seen_vec = 4'b0010;
        #1;
        check_eq("elect_origin", 32'(origin_vec), 32'h2);
        check_eq("elect_bcast",  32'(dl_detect_bcast), 32'h1);
        check_eq("elect_tclr",   32'(token_clear), 32'h0);

        // Loop trace 1 -> 2 -> 0 -> 1.
        step();
        token_seen_vec = 4'b0100;
        #1;
        check_eq("tr1_origin", 32'(origin_vec), 32'h0);
        check_eq("tr1_loop",   32'(loop_vec),   32'h2);
        check_eq("tr1_tclr",   32'(token_clear), 32'h0);
        step();
        token_seen_vec = 4'b0001;
        #1;
        check_eq("tr2_tclr", 32'(token_clear), 32'h0);
        check_eq("tr2_loop", 32'(loop_vec),    32'h6);
        step();
        token_seen_vec = 4'b0010;
        #1;
        check_eq("tr3_tclr",  32'(token_clear),  32'h1);
        check_eq("tr3_valid", 32'(report_valid), 32'h0);
        step();
        #1;
        check_eq("rep_valid",   32'(report_valid),  32'h1);
        check_eq("rep_loop",    32'(loop_vec),      32'h7);
        check_eq("rep_timeout", 32'(trace_timeout), 32'h0);
        check_eq("rep_global",  32'(dl_global),     32'h1);
        check_eq("rep_oidx",    32'(origin_idx),    32'h1);
        check_eq("rep_tclr",    32'(token_clear),   32'h0);
        check_eq("rep_bcast",   32'(dl_detect_bcast), 32'h1);
        token_seen_vec = 4'b0;

        // Ack with detect cleared: DONE then IDLE.
        dl_detect_vec = 4'b0;
        report_ack    = 1'b1;
        step();
        report_ack = 1'b0;
        #1;
        check_eq("ack_valid",  32'(report_valid), 32'h0);
        check_eq("ack_global", 32'(dl_global),    32'h1);
        check_eq("ack_loop",   32'(loop_vec),     32'h7);
        step();
        #1;
        check_eq("rearm_global", 32'(dl_global),       32'h0);
        check_eq("rearm_loop",   32'(loop_vec),        32'h0);
        check_eq("rearm_bcast",  32'(dl_detect_bcast), 32'h0);

        // Single-edge glitch on process 2 must not launch.
        dl_detect_vec = 4'b0100;
        step();
        dl_detect_vec = 4'b0;
        #1;
        check_eq("gl1_origin", 32'(origin_vec), 32'h0);
        step();
        #1;
        check_eq("gl2_origin", 32'(origin_vec),      32'h0);
        check_eq("gl2_global", 32'(dl_global),       32'h0);
        check_eq("gl2_bcast",  32'(dl_detect_bcast), 32'h0);
        step();
        #1;
        check_eq("gl3_origin", 32'(origin_vec), 32'h0);

        // Timeout: origin 1, token seen at process 2 once, never returns.
        dl_detect_vec = 4'b0010;
        step();
        step();
        #1;
        check_eq("to_origin", 32'(origin_vec), 32'h2);
        for (int i = 0; i < 8; i++) begin
            step();
            token_seen_vec = (i == 0) ? 4'b0100 : 4'b0000;
            #1;
            check_eq($sformatf("to_tclr%0d", i),  32'(token_clear),  32'h0);
            check_eq($sformatf("to_valid%0d", i), 32'(report_valid), 32'h0);
        end
        step();
        token_seen_vec = 4'b0;
        #1;
        check_eq("to_rep_valid",   32'(report_valid),  32'h1);
        check_eq("to_rep_timeout", 32'(trace_timeout), 32'h1);
        check_eq("to_rep_loop",    32'(loop_vec),      32'h6);
        check_eq("to_rep_global",  32'(dl_global),     32'h1);
        check_eq("to_rep_tclr",    32'(token_clear),   32'h0);

        // Ack with detect still held: stay in DONE, no second launch.
        report_ack = 1'b1;
        step();
        #1;
        check_eq("hold_valid", 32'(report_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            report_ack = 1'b0;
            #1;
            check_eq($sformatf("hold_global%0d", i),  32'(dl_global),      32'h1);
            check_eq($sformatf("hold_origin%0d", i),  32'(origin_vec),     32'h0);
            check_eq($sformatf("hold_timeout%0d", i), 32'(trace_timeout),  32'h1);
            check_eq($sformatf("hold_loop%0d", i),    32'(loop_vec),       32'h6);
            check_eq($sformatf("hold_bcast%0d", i),   32'(dl_detect_bcast), 32'h1);
        end

        // Release to IDLE, then reset asynchronously in the middle of a trace.
        dl_detect_vec = 4'b0;
        step();
        dl_detect_vec = 4'b1000;
        step();
        step();
        #1;
        check_eq("mid_origin", 32'(origin_vec), 32'h8);
        step();
        #1;
        check_eq("mid_bcast", 32'(dl_detect_bcast), 32'h1);
        check_eq("mid_loop",  32'(loop_vec),        32'h8);
        reset = 1'b1;
        #1;
        check_all_zero("arst");
        dl_detect_vec = 4'b0;
        #1;
        reset = 1'b0;
        step();
        #1;
        check_eq("post_bcast",  32'(dl_detect_bcast), 32'h0);
        check_eq("post_origin", 32'(origin_vec),      32'h0);
        check_eq("post_global", 32'(dl_global),       32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
